// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared constants and width helpers for arb_mux_rr.
// Holds default WIDTH/CHANNELS, clog2 and the out_sel width rule.
package arb_mux_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_CHANNELS = 10;

  // Smallest r with 2**r >= n.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Channel index width; at least one bit.
  function automatic int sel_w(input int n);
    int c;
    c = clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// rr_arbiter: round-robin search from ptr, or fixed grant when locked.
// Ports: req, ptr, lock, lock_id in; one-hot grant, grant_idx out.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int N  = DEF_CHANNELS,
  parameter int SW = sel_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          lock,
  input  logic [SW-1:0] lock_id,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (lock) begin
      // Locked: only the owner may go, even if idle.
      if (req[lock_id]) begin
        grant[lock_id] = 1'b1;
        grant_idx      = lock_id;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(ptr) + k) % N;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = SW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/arb_mux_rr.sv
// arb_mux_rr: round-robin N:1 mux with one registered output beat.
// Ports: in_bus/in_valid/in_last/in_ready -> out_*; ARB_MUX_LOCK_EN locks packets.
module arb_mux_rr
  import arb_mux_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [CHANNELS*WIDTH-1:0]   in_bus,
  input  logic [CHANNELS-1:0]         in_valid,
  input  logic [CHANNELS-1:0]         in_last,
  output logic [CHANNELS-1:0]         in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [sel_w(CHANNELS)-1:0]  out_sel,
  output logic                        out_valid,
  output logic                        out_last,
  input  logic                        out_ready
);

  localparam int SEL_W = sel_w(CHANNELS);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_last_q, out_last_d;

  logic                lock;
  logic [SEL_W-1:0]    lock_id;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    g_idx;
  logic [SEL_W-1:0]    g_next;
  logic                load_en;
  logic                xfer;

`ifdef ARB_MUX_LOCK_EN
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_id_q, lock_id_d;

  assign lock    = lock_q;
  assign lock_id = lock_id_q;
`else
  assign lock    = 1'b0;
  assign lock_id = '0;
`endif

  rr_arbiter #(
    .N  (CHANNELS),
    .SW (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (ptr_q),
    .lock      (lock),
    .lock_id   (lock_id),
    .grant     (grant),
    .grant_idx (g_idx)
  );

  assign load_en = !out_valid_q || out_ready;

  // rst_n gate keeps in_ready low while reset is held.
  assign in_ready = grant & {CHANNELS{load_en & rst_n}};
  assign xfer     = |in_ready;

  assign g_next = (g_idx == SEL_W'(CHANNELS - 1))
                ? '0 : g_idx + SEL_W'(1);

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_bus[int'(g_idx)*WIDTH +: WIDTH];
      out_sel_d   = g_idx;
      out_last_d  = in_last[g_idx];
      // While locked g_idx is the owner, so ptr stays put.
      ptr_d       = g_next;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

`ifdef ARB_MUX_LOCK_EN
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (xfer) begin
      lock_d    = !in_last[g_idx];
      lock_id_d = g_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_arb_mux_rr.sv
// tb_arb_mux_rr: vector table, directed sequences and random model check.
// Build with or without ARB_MUX_LOCK_EN.
module tb_arb_mux_rr;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_bus;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_valid;
  logic           out_last;
  logic           out_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arb_mux_rr #(
    .WIDTH    (W),
    .CHANNELS (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bus    (in_bus),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Output-side observer: delivered beats and their source order.
  int   delivered = 0;
  bit   rec = 0;
  int   outq[$];

  always @(posedge clk) begin
    if (out_valid && out_ready) begin
      delivered++;
      if (rec) outq.push_back(int'(out_sel));
    end
  end

  typedef struct {
    logic [3:0] vld;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [1:0] exp_sel;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[14];

  // Reference model state.
  int       m_ptr, m_sel, m_lid;
  bit       m_ov, m_last, m_lock;
  bit [7:0] m_data;

  function automatic int pick(input logic [3:0] v, input int p,
                              input bit lk, input int lid);
    if (lk) return v[lid] ? lid : -1;
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  initial begin
    int b, z, between, g;
    bit gap, r0, le;
    logic [3:0] er;

    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[5]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tbl[6]  = '{4'b1010, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h11};
    tbl[7]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h13};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 8'h13};
    tbl[10] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 8'h12};
    tbl[11] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tbl[12] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 8'h11};

    // Reset state with requests pending.
    rst_n     = 1'b0;
    in_bus    = 32'h13121110;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    #2;
    check("rst_ov", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sel", out_sel, 0);
    check("rst_last", out_last, 0);
    check("rst_rdy", in_ready, 0);
    in_valid = 4'b0000;
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: in_ready before the edge, output register after.
    for (int i = 0; i < 14; i++) begin
      in_valid  = tbl[i].vld;
      out_ready = tbl[i].ordy;
      #1;
      check($sformatf("vec%0d_rdy", i), in_ready, tbl[i].exp_rdy);
      @(posedge clk); #1;
      check($sformatf("vec%0d_ov", i), out_valid, tbl[i].exp_ov);
      check($sformatf("vec%0d_sel", i), out_sel, tbl[i].exp_sel);
      check($sformatf("vec%0d_data", i), out_data, tbl[i].exp_data);
    end

    // Backpressure: beat held stable, delivered exactly once.
    in_bus    = 32'h13AB1110;
    in_valid  = 4'b0100;
    out_ready = 1'b0;
    #1;
    check("bp_first_rdy", in_ready, 4'b0100);
    @(posedge clk); #1;
    delivered = 0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_ov", i), out_valid, 1);
      check($sformatf("bp%0d_data", i), out_data, 8'hAB);
      check($sformatf("bp%0d_sel", i), out_sel, 2);
      check($sformatf("bp%0d_rdy", i), in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_delivered", delivered, 1);
    check("bp_ov_clear", out_valid, 0);
    @(posedge clk); #1;
    check("bp_delivered_once", delivered, 1);

    // Packet of 3 beats on ch0 with a gap; ch1 always valid.
    b = 0;
    gap = 0;
    outq.delete();
    rec = 1;
    for (int c = 0; c < 40 && b < 3; c++) begin
      in_valid = {2'b00, 1'b1, !gap};
      in_bus   = {16'h0, 8'hB0, 8'(8'hA0 + b)};
      in_last  = {2'b00, 1'b1, (b == 2)};
      #1 r0 = in_ready[0];
      @(posedge clk); #1;
      if (gap) gap = 0;
      else if (r0) begin
        b++;
        if (b == 2) gap = 1;
      end
    end
    check("pkt_done", b, 3);
    in_valid = 4'b0000;
    repeat (3) @(posedge clk);
    #1 rec = 0;
    z = 0;
    between = 0;
    foreach (outq[i]) begin
      if (outq[i] == 0) z++;
      else if (z >= 1 && z < 3) between++;
    end
    check("pkt_ch0_beats", z, 3);
`ifdef ARB_MUX_LOCK_EN
    check("pkt_no_interleave", between, 0);
`else
    check("pkt_interleave", between > 0, 1);
`endif

    // Asynchronous reset with a beat held in the output register.
    in_bus    = 32'h4433225C;
    in_last   = 4'b1111;
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("ar_pre_ov", out_valid, 1);
    check("ar_pre_data", out_data, 8'h5C);
    #2 rst_n = 1'b0;
    #1;
    check("ar_ov", out_valid, 0);
    check("ar_data", out_data, 0);
    check("ar_sel", out_sel, 0);
    in_bus   = 32'h44332211;
    in_valid = 4'b1111;
    #1;
    check("ar_rdy", in_ready, 0);
    out_ready = 1'b1;
    #1 rst_n = 1'b1;
    #1;
    check("ar_rel_rdy", in_ready, 4'b0001);
    @(posedge clk); #1;
    check("ar_rel_ov", out_valid, 1);
    check("ar_rel_sel", out_sel, 0);
    check("ar_rel_data", out_data, 8'h11);

    m_ptr  = 1;
    m_ov   = 1;
    m_sel  = 0;
    m_data = 8'h11;
    m_last = 1;
    m_lock = 0;
    m_lid  = 0;

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom | $urandom);
      in_bus    = $urandom;
      out_ready = ($urandom % 4) != 0;
      #1;
      le = !m_ov || out_ready;
      g  = pick(in_valid, m_ptr, m_lock, m_lid);
      er = (le && g >= 0) ? 4'(1 << g) : 4'b0000;
      check($sformatf("rnd%0d_rdy", c), in_ready, er);
      @(posedge clk);
      if (le && g >= 0) begin
        m_ov   = 1;
        m_data = in_bus[g*W +: W];
        m_sel  = g;
        m_last = in_last[g];
        m_ptr  = (g + 1) % N;
`ifdef ARB_MUX_LOCK_EN
        m_lock = !in_last[g];
        m_lid  = g;
`endif
      end else if (out_ready) begin
        m_ov = 0;
      end
      #1;
      check($sformatf("rnd%0d_ov", c), out_valid, m_ov);
      check($sformatf("rnd%0d_sel", c), out_sel, m_sel);
      check($sformatf("rnd%0d_data", c), out_data, m_data);
      check($sformatf("rnd%0d_last", c), out_last, m_last);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
